// File: rtl/fsm_overlapping_pkg.sv
// Shared helpers for the overlapping serial pattern detector: state-width
// computation and the elaboration-time KMP transition function.
package fsm_overlapping_pkg;

  localparam int unsigned DefSeqLen = 4;
  localparam logic [15:0] DefSeq    = 16'h000B;

  // Ceiling log2; callers pass v >= 2 so the result is at least 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Next matched-prefix length from prefix length k on input bit b.
  // The received string is SEQ's first k bits followed by b; the result is the
  // longest j such that its last j bits equal SEQ's first j bits. A direct
  // extension (k < seq_len, b matching) falls out as j = k + 1.
  function automatic int unsigned next_state(input int unsigned k, input logic b,
                                             input logic [15:0] seq,
                                             input int unsigned seq_len);
    logic [16:0] s;
    int unsigned jmax;
    int unsigned result;
    logic        ok;
    s = '0;
    for (int unsigned i = 0; i < k; i++) begin
      s[i] = seq[seq_len - 1 - i];
    end
    s[k] = b;
    jmax = (k + 1 > seq_len) ? seq_len : k + 1;
    result = 0;
    // Ascending search: the last hit is the longest border.
    for (int unsigned j = 1; j <= jmax; j++) begin
      ok = 1'b1;
      for (int unsigned t = 0; t < j; t++) begin
        if (s[k + 1 - j + t] != seq[seq_len - 1 - t]) ok = 1'b0;
      end
      if (ok) result = j;
    end
    return result;
  endfunction

endpackage

// File: rtl/fsm_overlapping.sv
// Overlapping serial pattern detector (Moore). State is the matched-prefix
// length; dout is decoded from the state register so it is glitch-free and
// high for one cycle per completed match.
module fsm_overlapping
  import fsm_overlapping_pkg::*;
#(
  parameter int unsigned            SEQ_LEN = DefSeqLen,
  parameter logic [SEQ_LEN-1:0]     SEQ     = DefSeq[SEQ_LEN-1:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned SW       = clog2(SEQ_LEN + 1);
  localparam int unsigned NumSlots = 1 << SW;
  localparam logic [15:0] SeqExt   = 16'(SEQ);

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;

  // Constant transition tables; unreachable encodings fall back to S0.
  logic [SW-1:0] tbl0 [NumSlots];
  logic [SW-1:0] tbl1 [NumSlots];

  for (genvar k = 0; k < NumSlots; k++) begin : g_tbl
    if (k <= SEQ_LEN) begin : g_live
      assign tbl0[k] = SW'(next_state(k, 1'b0, SeqExt, SEQ_LEN));
      assign tbl1[k] = SW'(next_state(k, 1'b1, SeqExt, SEQ_LEN));
    end else begin : g_pad
      assign tbl0[k] = '0;
      assign tbl1[k] = '0;
    end
  end

  // State register with asynchronous clear to S0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state lookup: one bit consumed per edge.
  always_comb begin
    state_d = din ? tbl1[state_q] : tbl0[state_q];
  end

  assign dout = (state_q == SW'(SEQ_LEN));

endmodule

// File: tb/tb_fsm_overlapping.sv
// Bench for fsm_overlapping: sliding-window reference model checked every
// cycle, plus directed sequences with hand-written expected pulse trains.
module tb_fsm_overlapping;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic dout4;
  logic dout3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fsm_overlapping u_dut4 (
    .clk (clk),
    .rst (rst),
    .din (din),
    .dout(dout4)
  );

  fsm_overlapping #(
    .SEQ_LEN(3),
    .SEQ    (3'b111)
  ) u_dut3 (
    .clk (clk),
    .rst (rst),
    .din (din),
    .dout(dout3)
  );

  // Reference: a match is simply "last L bits since reset equal the pattern".
  logic [15:0] hist = '0;
  int          cnt  = 0;
  logic        exp4 = 1'b0;
  logic        exp3 = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist = '0;
      cnt  = 0;
      exp4 = 1'b0;
      exp3 = 1'b0;
    end else begin
      hist = {hist[14:0], din};
      if (cnt < 16) cnt = cnt + 1;
      exp4 = (cnt >= 4) && (hist[3:0] == 4'b1011);
      exp3 = (cnt >= 3) && (hist[2:0] == 3'b111);
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    #1;
    chk("cycle_dout4", dout4, exp4);
    chk("cycle_dout3", dout3, exp3);
  end

  // Called at a falling edge; leaves the bench at a falling edge with rst high.
  task automatic do_reset();
    rst = 1'b0;
    din = 1'b0;
    #1;
    chk("reset_async4", dout4, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("reset_hold4", dout4, 1'b0);
      chk("reset_hold3", dout3, 1'b0);
    end
    rst = 1'b1;
  endtask

  // Drive n bits MSB first from a falling edge; outs[n-i] holds dout after edge i.
  task automatic run_seq(input int n, input logic [15:0] bits,
                         output logic [15:0] outs4, output logic [15:0] outs3);
    outs4 = '0;
    outs3 = '0;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        @(negedge clk);
        outs4[n-i] = dout4;
        outs3[n-i] = dout3;
      end
      if (i < n) din = bits[n-1-i];
    end
  endtask

  logic [15:0] o4;
  logic [15:0] o3;

  initial begin
    @(negedge clk);
    do_reset();

    run_seq(7, 16'b1011110, o4, o3);
    chk_vec("single_match", o4, 16'b0001000);
    chk_vec("ones3_in_single", o3, 16'b0000110);

    do_reset();
    run_seq(7, 16'b1011011, o4, o3);
    chk_vec("overlap_two", o4, 16'b0001001);

    do_reset();
    run_seq(6, 16'b101011, o4, o3);
    chk_vec("fallback_s2", o4, 16'b000001);

    do_reset();
    run_seq(3, 16'b101, o4, o3);
    chk_vec("pre_reset_part", o4, 16'b000);
    rst = 1'b0;
    #1;
    chk("mid_reset_clear", dout4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    run_seq(1, 16'b1, o4, o3);
    chk_vec("no_straddle", o4, 16'b0);

    do_reset();
    run_seq(6, 16'b111111, o4, o3);
    chk_vec("ones_run3", o3, 16'b001111);

    // Pulling reset while dout is high must clear it without a clock edge.
    do_reset();
    run_seq(4, 16'b1011, o4, o3);
    chk_vec("pre_clear_match", o4, 16'b0001);
    rst = 1'b0;
    #1;
    chk("async_clear_high", dout4, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Random bits with occasional resets; the per-cycle compare does the checking.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      din = 1'($urandom_range(0, 1));
    end

    @(negedge clk);
    rst = 1'b1;
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
